// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if
//   Groups the three buses of the 16-bit ALU sequencer:
//     request  : req_valid/req_ready handshake with req_op, req_a, req_b
//     ALU bus  : alu_cmd, alu_a, alu_b, alu_sc_i out; alu_rslt, alu_sc_o, alu_cnd back
//     response : rsp_valid/rsp_ready handshake with rsp_rslt, rsp_sc, rsp_cnd, rsp_err
//   slave  : the sequencer's view
//   master : the requester / ALU / response consumer side
interface alu_sequencer_if;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [15:0] req_a;
   logic [15:0] req_b;

   logic [3:0]  alu_cmd;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic        alu_sc_i;
   logic [7:0]  alu_rslt;
   logic        alu_sc_o;
   logic        alu_cnd;

   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_rslt;
   logic        rsp_sc;
   logic        rsp_cnd;
   logic        rsp_err;

   modport slave (
      input  req_valid, req_op, req_a, req_b,
      output req_ready,
      output alu_cmd, alu_a, alu_b, alu_sc_i,
      input  alu_rslt, alu_sc_o, alu_cnd,
      output rsp_valid, rsp_rslt, rsp_sc, rsp_cnd, rsp_err,
      input  rsp_ready
   );

   modport master (
      output req_valid, req_op, req_a, req_b,
      input  req_ready,
      input  alu_cmd, alu_a, alu_b, alu_sc_i,
      output alu_rslt, alu_sc_o, alu_cnd,
      input  rsp_valid, rsp_rslt, rsp_sc, rsp_cnd, rsp_err,
      output rsp_ready
   );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Runs one 16-bit operation per accepted request on an external 8-bit
//   combinational ALU, one byte-step per clock, and returns the 16-bit result,
//   carry/shift-out, condition and error flag on a valid/ready response port.
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : alu_sequencer_if.slave (request, ALU and response buses)
// All outputs are registered; the ALU drive for a step is computed from the
// next state so it is valid for the whole cycle the step occupies.
module alu_sequencer (
   input  logic             clk,
   input  logic             reset_n,
   alu_sequencer_if.slave   bus
);

   typedef enum logic [2:0] {IDLE, STEP0, STEP1, STEP2, RESP} state_e;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_CMP = 4'b0100;
   localparam logic [3:0] OP_CEQ = 4'b0101;
   localparam logic [3:0] OP_LSL = 4'b0110;
   localparam logic [3:0] OP_LSR = 4'b0111;
   localparam logic [3:0] OP_MOV = 4'b1000;

   typedef struct packed {
      logic [3:0] cmd;
      logic [7:0] a;
      logic [7:0] b;
      logic       sc_i;
   } drive_t;

   // ALU drive for one step. Byte order and carry chaining depend on the op:
   // arithmetic and LSL go low byte first, LSR and the compares go high first.
   // SUB chains the inverted carry because the ALU reports "no borrow" as 1.
   function automatic drive_t step_drive(input logic [3:0]  op,
                                         input logic [1:0]  step,
                                         input logic [15:0] a,
                                         input logic [15:0] b,
                                         input logic        sc_prev);
      drive_t d;
      logic   hi;
      d     = '0;
      hi    = 1'b0;
      d.cmd = op;
      case (op)
         OP_ADD, OP_LSL: begin
            hi     = (step == 2'd1);
            d.sc_i = (step == 2'd1) & sc_prev;
         end
         OP_SUB: begin
            hi     = (step == 2'd1);
            d.sc_i = (step == 2'd1) & ~sc_prev;
         end
         OP_LSR: begin
            hi     = (step == 2'd0);
            d.sc_i = (step == 2'd1) & sc_prev;
         end
         OP_CMP: begin
            hi    = (step != 2'd2);
            d.cmd = (step == 2'd1) ? OP_CEQ : OP_CMP;
         end
         OP_CEQ: begin
            hi = (step == 2'd0);
         end
         default: begin
            hi = (step == 2'd1);
         end
      endcase
      d.a = hi ? a[15:8] : a[7:0];
      d.b = hi ? b[15:8] : b[7:0];
      return d;
   endfunction

   state_e      state_q, state_d;
   logic [3:0]  op_q, op_d;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic        sc_prev_q, sc_prev_d;
   logic        gt_hi_q, gt_hi_d;
   logic        eq_hi_q, eq_hi_d;
   logic [15:0] rslt_q, rslt_d;
   logic        sc_q, sc_d;
   logic        cnd_q, cnd_d;
   logic        err_q, err_d;

   logic        req_ready_q, req_ready_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [15:0] rsp_rslt_q, rsp_rslt_d;
   logic        rsp_sc_q, rsp_sc_d;
   logic        rsp_cnd_q, rsp_cnd_d;
   logic        rsp_err_q, rsp_err_d;
   logic [3:0]  alu_cmd_q, alu_cmd_d;
   logic [7:0]  alu_a_q, alu_a_d;
   logic [7:0]  alu_b_q, alu_b_d;
   logic        alu_sc_i_q, alu_sc_i_d;

   drive_t      drive;
   logic        cmp_like;

   // Next-state, result accumulation and registered-output computation.
   // Work registers (rslt/sc/cnd/err) are cleared at accept so ops that never
   // capture a field (compares, invalid ops) report zero there.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      sc_prev_d = sc_prev_q;
      gt_hi_d   = gt_hi_q;
      eq_hi_d   = eq_hi_q;
      rslt_d    = rslt_q;
      sc_d      = sc_q;
      cnd_d     = cnd_q;
      err_d     = err_q;
      drive     = '0;
      cmp_like  = (op_q == OP_CMP) || (op_q == OP_CEQ);

      case (state_q)
         IDLE: begin
            if (bus.req_valid && req_ready_q) begin
               op_d      = bus.req_op;
               a_d       = bus.req_a;
               b_d       = bus.req_b;
               sc_prev_d = 1'b0;
               gt_hi_d   = 1'b0;
               eq_hi_d   = 1'b0;
               rslt_d    = '0;
               sc_d      = 1'b0;
               cnd_d     = 1'b0;
               err_d     = (bus.req_op > OP_MOV);
               state_d   = (bus.req_op > OP_MOV) ? RESP : STEP0;
            end
         end
         STEP0: begin
            sc_prev_d = bus.alu_sc_o;
            gt_hi_d   = bus.alu_cnd;
            eq_hi_d   = bus.alu_cnd;
            if (op_q == OP_LSR) begin
               rslt_d[15:8] = bus.alu_rslt;
            end else if (!cmp_like) begin
               rslt_d[7:0] = bus.alu_rslt;
            end
            state_d = STEP1;
         end
         STEP1: begin
            if (op_q == OP_CMP) begin
               eq_hi_d = bus.alu_cnd;
               state_d = STEP2;
            end else begin
               state_d = RESP;
               if (op_q == OP_CEQ) begin
                  cnd_d = eq_hi_q & bus.alu_cnd;
               end else if (op_q == OP_LSR) begin
                  rslt_d[7:0] = bus.alu_rslt;
               end else begin
                  rslt_d[15:8] = bus.alu_rslt;
               end
               if (op_q inside {OP_ADD, OP_SUB, OP_LSL, OP_LSR}) begin
                  sc_d = bus.alu_sc_o;
               end
            end
         end
         STEP2: begin
            cnd_d   = gt_hi_q | (eq_hi_q & bus.alu_cnd);
            state_d = RESP;
         end
         RESP: begin
            if (rsp_valid_q && bus.rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      case (state_d)
         STEP0:   drive = step_drive(op_d, 2'd0, a_d, b_d, sc_prev_d);
         STEP1:   drive = step_drive(op_d, 2'd1, a_d, b_d, sc_prev_d);
         STEP2:   drive = step_drive(op_d, 2'd2, a_d, b_d, sc_prev_d);
         default: drive = '0;
      endcase

      alu_cmd_d  = drive.cmd;
      alu_a_d    = drive.a;
      alu_b_d    = drive.b;
      alu_sc_i_d = drive.sc_i;

      // An invalid op jumps straight to RESP at accept; it holds off rsp_valid
      // for that first RESP cycle so its response appears one edge later.
      req_ready_d = (state_d == IDLE);
      rsp_valid_d = (state_d == RESP) && (state_q != IDLE);
      rsp_rslt_d  = rsp_valid_d ? rslt_d : '0;
      rsp_sc_d    = rsp_valid_d & sc_d;
      rsp_cnd_d   = rsp_valid_d & cnd_d;
      rsp_err_d   = rsp_valid_d & err_d;
   end

   // State and output registers; reset forces IDLE with every output low,
   // including req_ready, which comes up on the first edge after release.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         sc_prev_q   <= 1'b0;
         gt_hi_q     <= 1'b0;
         eq_hi_q     <= 1'b0;
         rslt_q      <= '0;
         sc_q        <= 1'b0;
         cnd_q       <= 1'b0;
         err_q       <= 1'b0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rslt_q  <= '0;
         rsp_sc_q    <= 1'b0;
         rsp_cnd_q   <= 1'b0;
         rsp_err_q   <= 1'b0;
         alu_cmd_q   <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_sc_i_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sc_prev_q   <= sc_prev_d;
         gt_hi_q     <= gt_hi_d;
         eq_hi_q     <= eq_hi_d;
         rslt_q      <= rslt_d;
         sc_q        <= sc_d;
         cnd_q       <= cnd_d;
         err_q       <= err_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rslt_q  <= rsp_rslt_d;
         rsp_sc_q    <= rsp_sc_d;
         rsp_cnd_q   <= rsp_cnd_d;
         rsp_err_q   <= rsp_err_d;
         alu_cmd_q   <= alu_cmd_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_sc_i_q  <= alu_sc_i_d;
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rslt  = rsp_rslt_q;
   assign bus.rsp_sc    = rsp_sc_q;
   assign bus.rsp_cnd   = rsp_cnd_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.alu_cmd   = alu_cmd_q;
   assign bus.alu_a     = alu_a_q;
   assign bus.alu_b     = alu_b_q;
   assign bus.alu_sc_i  = alu_sc_i_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
//   Self-checking bench for alu_sequencer. Models the 8-bit ALU, applies a
//   table of hand-computed vectors plus model-derived random vectors, and runs
//   a hand-written mid-operation reset sequence. Expected responses go into a
//   scoreboard queue at accept and are popped when the response appears.
module tb_alu_sequencer;

   typedef struct {
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] rslt;
      logic        sc;
      logic        cnd;
      logic        err;
      int          lat;
      logic [11:0] cmds;
      int          stall;
   } vec_t;

   logic clk;
   logic reset_n;

   alu_sequencer_if bus ();

   alu_sequencer dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int   n_vectors;
   int   n_checks;
   int   n_miscompares;
   vec_t sb_q[$];
   vec_t vecs[21];
   logic [8:0] alu_tmp;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural 8-bit ALU: SUB reports sc_o = 1 for "no borrow";
   // shifts and MOV take their operand from alu_b.
   always_comb begin
      alu_tmp      = '0;
      bus.alu_rslt = '0;
      bus.alu_sc_o = 1'b0;
      bus.alu_cnd  = 1'b0;
      case (bus.alu_cmd)
         4'h0: begin
            alu_tmp      = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {8'b0, bus.alu_sc_i};
            bus.alu_rslt = alu_tmp[7:0];
            bus.alu_sc_o = alu_tmp[8];
         end
         4'h1: begin
            alu_tmp      = {1'b0, bus.alu_a} - {1'b0, bus.alu_b} - {8'b0, bus.alu_sc_i};
            bus.alu_rslt = alu_tmp[7:0];
            bus.alu_sc_o = ~alu_tmp[8];
         end
         4'h2: bus.alu_rslt = bus.alu_a & bus.alu_b;
         4'h3: bus.alu_rslt = bus.alu_a ^ bus.alu_b;
         4'h4: bus.alu_cnd  = (bus.alu_a > bus.alu_b);
         4'h5: bus.alu_cnd  = (bus.alu_a == bus.alu_b);
         4'h6: begin
            bus.alu_rslt = {bus.alu_b[6:0], bus.alu_sc_i};
            bus.alu_sc_o = bus.alu_b[7];
         end
         4'h7: begin
            bus.alu_rslt = {bus.alu_sc_i, bus.alu_b[7:1]};
            bus.alu_sc_o = bus.alu_b[0];
         end
         4'h8: bus.alu_rslt = bus.alu_b;
         default: bus.alu_rslt = '0;
      endcase
   end

   function automatic vec_t mk(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] rslt, input logic sc, input logic cnd,
                               input logic err, input int lat, input logic [11:0] cmds,
                               input int stall);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.rslt = rslt; v.sc = sc; v.cnd = cnd;
      v.err = err; v.lat = lat; v.cmds = cmds; v.stall = stall;
      return v;
   endfunction

   // Whole-word reference for the 16-bit operations.
   function automatic vec_t ref_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      vec_t        v;
      logic [16:0] s;
      v = mk(op, a, b, 16'h0, 1'b0, 1'b0, 1'b0, 2, {4'h0, op, op}, 0);
      case (op)
         4'h0: begin s = {1'b0, a} + {1'b0, b}; v.rslt = s[15:0]; v.sc = s[16]; end
         4'h1: begin v.rslt = a - b; v.sc = (a >= b); end
         4'h2: v.rslt = a & b;
         4'h3: v.rslt = a ^ b;
         4'h4: begin v.cnd = (a > b); v.lat = 3; v.cmds = 12'h454; end
         4'h5: begin v.cnd = (a == b); v.cmds = 12'h055; end
         4'h6: begin v.rslt = {b[14:0], 1'b0}; v.sc = b[15]; end
         4'h7: begin v.rslt = {1'b0, b[15:1]}; v.sc = b[0]; end
         4'h8: v.rslt = b;
         default: begin v.err = 1'b1; v.lat = 1; v.cmds = 12'h000; end
      endcase
      return v;
   endfunction

   task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic checkOutput(input int idx, input int lat, input logic [11:0] cmds, input logic ready_low);
      vec_t e;
      if (sb_q.size() == 0) begin
         checkValue($sformatf("v%0d scoreboard_empty", idx), 32'd0, 32'd1);
         return;
      end
      e = sb_q.pop_front();
      checkValue($sformatf("v%0d rslt", idx),    32'(bus.rsp_rslt), 32'(e.rslt));
      checkValue($sformatf("v%0d sc", idx),      32'(bus.rsp_sc),   32'(e.sc));
      checkValue($sformatf("v%0d cnd", idx),     32'(bus.rsp_cnd),  32'(e.cnd));
      checkValue($sformatf("v%0d err", idx),     32'(bus.rsp_err),  32'(e.err));
      checkValue($sformatf("v%0d latency", idx), 32'(lat),          32'(e.lat));
      checkValue($sformatf("v%0d alu_cmds", idx), 32'(cmds),        32'(e.cmds));
      checkValue($sformatf("v%0d busy_ready_low", idx), 32'(ready_low), 32'd1);
      checkValue($sformatf("v%0d resp_alu_idle", idx),
                 32'({bus.alu_cmd, bus.alu_a, bus.alu_b, bus.alu_sc_i}), 32'd0);
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      int          cnt;
      int          n;
      logic [11:0] cmds;
      logic        ready_low;
      logic [18:0] snap;
      cnt = 0;
      while (!bus.req_ready && cnt < 20) begin
         @(posedge clk); #1;
         cnt++;
      end
      if (!bus.req_ready) begin
         checkValue($sformatf("v%0d ready_timeout", idx), 32'd0, 32'd1);
         return;
      end
      bus.req_valid = 1'b1;
      bus.req_op    = v.op;
      bus.req_a     = v.a;
      bus.req_b     = v.b;
      @(posedge clk); #1;
      sb_q.push_back(v);
      n_vectors++;
      // Keep a junk request pending while busy: it must neither disturb the
      // registered operands nor be queued.
      bus.req_op = 4'($urandom);
      bus.req_a  = 16'($urandom);
      bus.req_b  = 16'($urandom);
      n         = 0;
      cmds      = '0;
      ready_low = 1'b1;
      while (!bus.rsp_valid && n < 10) begin
         if (n < 3) cmds[n*4 +: 4] = bus.alu_cmd;
         if (bus.req_ready) ready_low = 1'b0;
         @(posedge clk); #1;
         n++;
      end
      if (!bus.rsp_valid) begin
         checkValue($sformatf("v%0d rsp_timeout", idx), 32'd0, 32'd1);
         void'(sb_q.pop_front());
         bus.req_valid = 1'b0;
         return;
      end
      checkOutput(idx, n, cmds, ready_low);
      snap = {bus.rsp_rslt, bus.rsp_sc, bus.rsp_cnd, bus.rsp_err};
      for (int s = 0; s < v.stall; s++) begin
         @(posedge clk); #1;
         checkValue($sformatf("v%0d stall%0d hold", idx, s),
                    32'({bus.rsp_valid, bus.rsp_rslt, bus.rsp_sc, bus.rsp_cnd, bus.rsp_err}),
                    32'({1'b1, snap}));
         checkValue($sformatf("v%0d stall%0d req_ready", idx, s), 32'(bus.req_ready), 32'd0);
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      checkValue($sformatf("v%0d rsp_valid_drop", idx), 32'(bus.rsp_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      n_vectors     = 0;
      n_checks      = 0;
      n_miscompares = 0;
      reset_n       = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_op    = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b0;

      vecs[0]  = mk(4'h0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0, 2, 12'h000, 0);
      vecs[1]  = mk(4'h0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 2, 12'h000, 0);
      vecs[2]  = mk(4'h1, 16'h0100, 16'h0001, 16'h00FF, 1'b1, 1'b0, 1'b0, 2, 12'h011, 0);
      vecs[3]  = mk(4'h1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0, 2, 12'h011, 0);
      vecs[4]  = mk(4'h4, 16'h1200, 16'h11FF, 16'h0000, 1'b0, 1'b1, 1'b0, 3, 12'h454, 0);
      vecs[5]  = mk(4'h4, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 3, 12'h454, 0);
      vecs[6]  = mk(4'h5, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0, 2, 12'h055, 0);
      vecs[7]  = mk(4'h6, 16'h5555, 16'h8001, 16'h0002, 1'b1, 1'b0, 1'b0, 2, 12'h066, 0);
      vecs[8]  = mk(4'h7, 16'h5555, 16'h8001, 16'h4000, 1'b1, 1'b0, 1'b0, 2, 12'h077, 0);
      vecs[9]  = mk(4'h3, 16'hF0F0, 16'h0FF0, 16'hFF00, 1'b0, 1'b0, 1'b0, 2, 12'h033, 5);
      vecs[10] = mk(4'hA, 16'h1111, 16'h2222, 16'h0000, 1'b0, 1'b0, 1'b1, 1, 12'h000, 0);
      vecs[11] = mk(4'h2, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b0, 2, 12'h022, 0);
      vecs[12] = mk(4'h8, 16'h1234, 16'hABCD, 16'hABCD, 1'b0, 1'b0, 1'b0, 2, 12'h088, 0);
      vecs[13] = mk(4'h5, 16'h1234, 16'h1235, 16'h0000, 1'b0, 1'b0, 1'b0, 2, 12'h055, 0);
      vecs[14] = mk(4'h4, 16'h11FF, 16'h1200, 16'h0000, 1'b0, 1'b0, 1'b0, 3, 12'h454, 0);
      vecs[15] = mk(4'h4, 16'h1201, 16'h1200, 16'h0000, 1'b0, 1'b1, 1'b0, 3, 12'h454, 0);
      vecs[16] = mk(4'hF, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1, 1, 12'h000, 0);
      vecs[17] = mk(4'h1, 16'h1234, 16'h0034, 16'h1200, 1'b1, 1'b0, 1'b0, 2, 12'h011, 0);
      vecs[18] = mk(4'h0, 16'h0080, 16'h0080, 16'h0100, 1'b0, 1'b0, 1'b0, 2, 12'h000, 0);
      vecs[19] = mk(4'h7, 16'h0000, 16'h0100, 16'h0080, 1'b0, 1'b0, 1'b0, 2, 12'h077, 0);
      vecs[20] = mk(4'h6, 16'h0000, 16'h0080, 16'h0100, 1'b0, 1'b0, 1'b0, 2, 12'h066, 0);

      #1 reset_n = 1'b0;
      #10;
      checkValue("reset req_ready", 32'(bus.req_ready), 32'd0);
      checkValue("reset rsp_outputs",
                 32'({bus.rsp_valid, bus.rsp_rslt, bus.rsp_sc, bus.rsp_cnd, bus.rsp_err}), 32'd0);
      checkValue("reset alu_outputs",
                 32'({bus.alu_cmd, bus.alu_a, bus.alu_b, bus.alu_sc_i}), 32'd0);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;
      checkValue("post_reset req_ready", 32'(bus.req_ready), 32'd1);

      for (int i = 0; i < 21; i++) begin
         applyStimulus(vecs[i], i);
      end

      for (int i = 0; i < 8; i++) begin
         applyStimulus(ref_model(4'($urandom_range(8)), 16'($urandom), 16'($urandom)), 100 + i);
      end

      // Reset while an ADD is in STEP1: everything drops at once and the
      // in-flight operation never responds.
      bus.req_valid = 1'b1;
      bus.req_op    = 4'h0;
      bus.req_a     = 16'h1234;
      bus.req_b     = 16'h4321;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      @(posedge clk); #1;
      checkValue("midreset step1 drive",
                 32'({bus.alu_cmd, bus.alu_a, bus.alu_b, bus.alu_sc_i}),
                 32'({4'h0, 8'h12, 8'h43, 1'b0}));
      reset_n = 1'b0;
      #1;
      checkValue("midreset req_ready", 32'(bus.req_ready), 32'd0);
      checkValue("midreset rsp_outputs",
                 32'({bus.rsp_valid, bus.rsp_rslt, bus.rsp_sc, bus.rsp_cnd, bus.rsp_err}), 32'd0);
      checkValue("midreset alu_outputs",
                 32'({bus.alu_cmd, bus.alu_a, bus.alu_b, bus.alu_sc_i}), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;
      checkValue("midreset release req_ready", 32'(bus.req_ready), 32'd1);
      for (int k = 0; k < 4; k++) begin
         checkValue($sformatf("midreset no_rsp%0d", k), 32'(bus.rsp_valid), 32'd0);
         @(posedge clk); #1;
      end
      applyStimulus(vecs[0], 200);

      checkValue("scoreboard drained", 32'(sb_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
